// File: rtl/grid_game_engine.sv
// N x N, K-in-a-row two-party board engine: valid/ready move intake, turn and legality
// checks, a scanner that walks only the four lines through the last move, draw and restart.
module grid_game_engine #(
    parameter int N = 3,
    parameter int K = 3,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          move_valid,
    output logic          move_ready,
    input  logic [1:0]    move_who,
    input  logic [CW-1:0] move_row,
    input  logic [CW-1:0] move_col,
    output logic          move_ack,
    output logic          move_err,
    output logic [1:0]    turn,
    input  logic [CW-1:0] rd_row,
    input  logic [CW-1:0] rd_col,
    output logic [1:0]    rd_cell,
    output logic [7:0]    move_count,
    output logic          game_over,
    output logic [1:0]    winner,
    output logic          draw
);

    localparam int IW = (N * N > 1) ? $clog2(N * N) : 1;
    localparam int SW = CW + 2;
    localparam logic [CW:0]            N_EXT   = (CW + 1)'(N);
    localparam logic signed [SW-1:0]   N_S     = SW'(N);
    localparam logic signed [SW-1:0]   OFF_MAX = SW'(K - 1);
    localparam logic signed [SW-1:0]   OFF_MIN = -OFF_MAX;
    localparam logic signed [SW-1:0]   ONE_S   = SW'(1);
    localparam logic [SW-1:0]          ONE_U   = SW'(1);
    localparam logic [SW-1:0]          RUN_WIN = SW'(K);
    localparam logic [7:0]             CELLS   = 8'(N * N);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MOVE,
        CHECK,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             board_q [N*N];
    logic [1:0]             board_d [N*N];
    logic [1:0]             turn_q, turn_d;
    logic [7:0]             count_q, count_d;
    logic [1:0]             winner_q, winner_d;
    logic                   draw_q, draw_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic [CW-1:0]          lastRow_q, lastRow_d;
    logic [CW-1:0]          lastCol_q, lastCol_d;
    logic [1:0]             lastWho_q, lastWho_d;
    logic [1:0]             dir_q, dir_d;
    logic signed [SW-1:0]   off_q, off_d;
    logic [SW-1:0]          run_q, run_d;

    logic                   moveInRange;
    logic [IW-1:0]          moveIdx;
    logic                   moveLegal;
    logic                   rdInRange;
    logic [IW-1:0]          rdIdx;
    logic signed [SW-1:0]   baseRow, baseCol;
    logic signed [SW-1:0]   scanRow, scanCol;
    logic                   scanInBounds;
    logic [IW-1:0]          scanIdx;
    logic                   scanHit;
    logic [SW-1:0]          runNext;

    assign moveInRange = ({1'b0, move_row} < N_EXT) && ({1'b0, move_col} < N_EXT);
    assign moveIdx     = IW'(int'(move_row) * N + int'(move_col));
    assign moveLegal   = moveInRange
                      && ((move_who == 2'b01) || (move_who == 2'b10))
                      && (move_who == turn_q)
                      && (board_q[moveIdx] == 2'b00);

    assign rdInRange = ({1'b0, rd_row} < N_EXT) && ({1'b0, rd_col} < N_EXT);
    assign rdIdx     = IW'(int'(rd_row) * N + int'(rd_col));
    assign rd_cell   = rdInRange ? board_q[rdIdx] : 2'b00;

    assign baseRow = $signed(SW'(lastRow_q));
    assign baseCol = $signed(SW'(lastCol_q));

    // Direction order: along the row, down the column, main diagonal, anti-diagonal.
    always_comb begin
        scanRow = baseRow;
        scanCol = baseCol;
        case (dir_q)
            2'd0: scanCol = baseCol + off_q;
            2'd1: scanRow = baseRow + off_q;
            2'd2: begin
                scanRow = baseRow + off_q;
                scanCol = baseCol + off_q;
            end
            default: begin
                scanRow = baseRow + off_q;
                scanCol = baseCol - off_q;
            end
        endcase
    end

    assign scanInBounds = !scanRow[SW-1] && (scanRow < N_S) && !scanCol[SW-1] && (scanCol < N_S);
    assign scanIdx      = IW'(int'(scanRow[CW-1:0]) * N + int'(scanCol[CW-1:0]));
    assign scanHit      = scanInBounds && (board_q[scanIdx] == lastWho_q);
    assign runNext      = scanHit ? (run_q + ONE_U) : '0;

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        turn_d    = turn_q;
        count_d   = count_q;
        winner_d  = winner_q;
        draw_d    = draw_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        lastRow_d = lastRow_q;
        lastCol_d = lastCol_q;
        lastWho_d = lastWho_q;
        dir_d     = dir_q;
        off_d     = off_q;
        run_d     = run_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    for (int i = 0; i < N * N; i++) begin
                        board_d[i] = 2'b00;
                    end
                    turn_d   = 2'b01;
                    count_d  = '0;
                    winner_d = 2'b00;
                    draw_d   = 1'b0;
                    state_d  = WAIT_MOVE;
                end
            end
            WAIT_MOVE: begin
                if (move_valid) begin
                    if (moveLegal) begin
                        board_d[moveIdx] = move_who;
                        count_d   = count_q + 8'd1;
                        ack_d     = 1'b1;
                        lastRow_d = move_row;
                        lastCol_d = move_col;
                        lastWho_d = move_who;
                        dir_d     = 2'd0;
                        off_d     = OFF_MIN;
                        run_d     = '0;
                        state_d   = CHECK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CHECK: begin
                if (runNext == RUN_WIN) begin
                    winner_d = lastWho_q;
                    turn_d   = 2'b00;
                    state_d  = DONE;
                end else if (off_q == OFF_MAX) begin
                    // A run never carries across directions.
                    run_d = '0;
                    off_d = OFF_MIN;
                    if (dir_q == 2'd3) begin
                        if (count_q == CELLS) begin
                            draw_d  = 1'b1;
                            turn_d  = 2'b00;
                            state_d = DONE;
                        end else begin
                            turn_d  = (turn_q == 2'b01) ? 2'b10 : 2'b01;
                            state_d = WAIT_MOVE;
                        end
                    end else begin
                        dir_d = dir_q + 2'd1;
                    end
                end else begin
                    run_d = runNext;
                    off_d = off_q + ONE_S;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            for (int i = 0; i < N * N; i++) begin
                board_q[i] <= 2'b00;
            end
            turn_q    <= 2'b00;
            count_q   <= '0;
            winner_q  <= 2'b00;
            draw_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            lastRow_q <= '0;
            lastCol_q <= '0;
            lastWho_q <= 2'b00;
            dir_q     <= 2'd0;
            off_q     <= '0;
            run_q     <= '0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            turn_q    <= turn_d;
            count_q   <= count_d;
            winner_q  <= winner_d;
            draw_q    <= draw_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            lastRow_q <= lastRow_d;
            lastCol_q <= lastCol_d;
            lastWho_q <= lastWho_d;
            dir_q     <= dir_d;
            off_q     <= off_d;
            run_q     <= run_d;
        end
    end

    assign move_ready = (state_q == WAIT_MOVE);
    assign game_over  = (state_q == DONE);
    assign move_ack   = ack_q;
    assign move_err   = err_q;
    assign turn       = turn_q;
    assign move_count = count_q;
    assign winner     = winner_q;
    assign draw       = draw_q;

endmodule

// File: tb/tb_grid_game_engine.sv
// Drives a 3x3/K=3 engine and a 5x5/K=4 engine with directed and random moves,
// comparing every response with a whole-board reference model of the game rules.
module tb_grid_game_engine;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start [2];
    logic       valid [2];
    logic [1:0] who   [2];
    logic [1:0] rowA, colA, rdRowA, rdColA;
    logic [2:0] rowB, colB, rdRowB, rdColB;
    logic       ready [2];
    logic       ack   [2];
    logic       err   [2];
    logic       over  [2];
    logic       drawO [2];
    logic [1:0] turnO [2];
    logic [1:0] winO  [2];
    logic [1:0] rdCell[2];
    logic [7:0] countO[2];

    int total = 0;
    int bad   = 0;

    int mBoard [2][5][5];
    int mTurn  [2];
    int mCount [2];
    int mWinner[2];
    int mDraw  [2];
    bit mOver  [2];
    bit mInGame[2];

    grid_game_engine #(.N(3), .K(3)) dutA (
        .clock(clock), .reset(reset), .start(start[0]), .move_valid(valid[0]),
        .move_ready(ready[0]), .move_who(who[0]), .move_row(rowA), .move_col(colA),
        .move_ack(ack[0]), .move_err(err[0]), .turn(turnO[0]), .rd_row(rdRowA),
        .rd_col(rdColA), .rd_cell(rdCell[0]), .move_count(countO[0]),
        .game_over(over[0]), .winner(winO[0]), .draw(drawO[0])
    );

    grid_game_engine #(.N(5), .K(4)) dutB (
        .clock(clock), .reset(reset), .start(start[1]), .move_valid(valid[1]),
        .move_ready(ready[1]), .move_who(who[1]), .move_row(rowB), .move_col(colB),
        .move_ack(ack[1]), .move_err(err[1]), .turn(turnO[1]), .rd_row(rdRowB),
        .rd_col(rdColB), .rd_cell(rdCell[1]), .move_count(countO[1]),
        .game_over(over[1]), .winner(winO[1]), .draw(drawO[1])
    );

    always #50 clock = ~clock;

    function automatic int nOf(input int u);
        return (u == 0) ? 3 : 5;
    endfunction

    function automatic int kOf(input int u);
        return (u == 0) ? 3 : 4;
    endfunction

    // Any K-long line anywhere on the model board owned by w.
    function automatic bit hasWin(input int u, input int w);
        int n, k, run, rr, cc;
        int dr [4];
        int dc [4];
        n = nOf(u);
        k = kOf(u);
        dr = '{0, 1, 1, 1};
        dc = '{1, 0, 1, -1};
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                for (int d = 0; d < 4; d++) begin
                    run = 0;
                    for (int s = 0; s < k; s++) begin
                        rr = r + s * dr[d];
                        cc = c + s * dc[d];
                        if (rr >= 0 && rr < n && cc >= 0 && cc < n && mBoard[u][rr][cc] == w) run++;
                    end
                    if (run == k) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clearModel(input int u);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                mBoard[u][r][c] = 0;
        mTurn[u] = 0; mCount[u] = 0; mWinner[u] = 0; mDraw[u] = 0;
        mOver[u] = 1'b0; mInGame[u] = 1'b0;
    endtask

    task automatic setRead(input int u, input int r, input int c);
        if (u == 0) begin rdRowA = 2'(r); rdColA = 2'(c); end
        else begin rdRowB = 3'(r); rdColB = 3'(c); end
    endtask

    task automatic checkBoard(input int u);
        int n, exp;
        n = nOf(u);
        tick();
        for (int r = 0; r <= n; r++) begin
            for (int c = 0; c <= n; c++) begin
                setRead(u, r, c);
                #1;
                exp = (r < n && c < n) ? mBoard[u][r][c] : 0;
                checkOutput("cell", rdCell[u], exp);
            end
        end
    endtask

    task automatic checkStatus(input int u);
        checkOutput("turn", turnO[u], mTurn[u]);
        checkOutput("count", countO[u], mCount[u]);
        checkOutput("winner", winO[u], mWinner[u]);
        checkOutput("draw", drawO[u], mDraw[u]);
        checkOutput("gameOver", over[u], mOver[u]);
        checkOutput("ready", ready[u], mInGame[u]);
    endtask

    task automatic startGame(input int u);
        start[u] = 1'b1;
        tick();
        start[u] = 1'b0;
        clearModel(u);
        mTurn[u] = 1;
        mInGame[u] = 1'b1;
        checkStatus(u);
    endtask

    // Offer one move, then follow the engine through its scan back to ready or game over.
    task automatic applyStimulus(input int u, input int w, input int r, input int c);
        int n, lat, cycles;
        bit legal;
        n = nOf(u);
        lat = 4 * (2 * kOf(u) - 1);
        legal = 1'b0;
        if (mInGame[u] && w == mTurn[u] && r < n && c < n) legal = (mBoard[u][r][c] == 0);
        valid[u] = 1'b1;
        who[u] = 2'(w);
        if (u == 0) begin rowA = 2'(r); colA = 2'(c); end
        else begin rowB = 3'(r); colB = 3'(c); end
        tick();
        valid[u] = 1'b0;
        checkOutput("ack", ack[u], legal);
        checkOutput("err", err[u], mInGame[u] && !legal);
        if (!legal) begin
            tick();
            checkOutput("ackAfter", ack[u], 0);
            checkOutput("errAfter", err[u], 0);
            checkStatus(u);
            return;
        end
        mBoard[u][r][c] = w;
        mCount[u]++;
        checkOutput("countOnAck", countO[u], mCount[u]);
        cycles = 0;
        do begin
            tick();
            cycles++;
            if (cycles == 1) begin
                checkOutput("ackPulse", ack[u], 0);
                checkOutput("errPulse", err[u], 0);
            end
        end while (!(ready[u] || over[u]) && cycles < 200);
        if (hasWin(u, w)) begin
            mWinner[u] = w; mTurn[u] = 0; mOver[u] = 1'b1; mInGame[u] = 1'b0;
            checkOutput("winLatency", cycles <= lat, 1);
        end else begin
            checkOutput("latency", cycles, lat);
            if (mCount[u] == n * n) begin
                mDraw[u] = 1; mTurn[u] = 0; mOver[u] = 1'b1; mInGame[u] = 1'b0;
            end else begin
                mTurn[u] = 3 - mTurn[u];
            end
        end
        checkStatus(u);
        setRead(u, r, c);
        #1;
        checkOutput("movedCell", rdCell[u], w);
    endtask

    task automatic randomMove(input int u);
        int n, w, r, c, s, p;
        bit found;
        n = nOf(u);
        if ($urandom_range(0, 3) == 0) begin
            w = $urandom_range(0, 3);
            r = $urandom_range(0, (u == 0) ? 3 : 7);
            c = $urandom_range(0, (u == 0) ? 3 : 7);
        end else begin
            w = mTurn[u];
            r = 0; c = 0;
            found = 1'b0;
            s = $urandom_range(0, n * n - 1);
            for (int i = 0; i < n * n; i++) begin
                p = (s + i) % (n * n);
                if (!found && mBoard[u][p / n][p % n] == 0) begin
                    r = p / n; c = p % n; found = 1'b1;
                end
            end
        end
        applyStimulus(u, w, r, c);
    endtask

    task automatic resetAll();
        reset = 1'b0;
        #1;
        clearModel(0);
        clearModel(1);
        for (int u = 0; u < 2; u++) begin
            checkStatus(u);
            checkOutput("ackRst", ack[u], 0);
            checkOutput("errRst", err[u], 0);
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0; valid[u] = 1'b0; who[u] = 2'b00;
            clearModel(u);
        end
        rowA = '0; colA = '0; rdRowA = '0; rdColA = '0;
        rowB = '0; colB = '0; rdRowB = '0; rdColB = '0;

        #3;
        resetAll();
        checkBoard(0);
        checkBoard(1);
        reset = 1'b1;
        tick();

        $display("[TB] moves ignored while idle");
        applyStimulus(0, 1, 0, 0);

        $display("[TB] occupied cell rejected, start ignored mid-game");
        startGame(0);
        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 2, 1, 1);
        checkOutput("occupiedKept", mBoard[0][1][1] == 1 && rdCell[0] == 2'b01, 1);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        checkStatus(0);

        tick();
        resetAll();
        reset = 1'b1;
        tick();

        $display("[TB] wrong mover and out-of-range row, then a drawn game");
        startGame(0);
        applyStimulus(0, 2, 0, 0);
        applyStimulus(0, 1, 3, 0);
        applyStimulus(0, 3, 0, 0);
        checkBoard(0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 2, 0, 1);
        applyStimulus(0, 1, 0, 2);
        applyStimulus(0, 2, 1, 1);
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 2, 1, 2);
        applyStimulus(0, 1, 2, 1);
        applyStimulus(0, 2, 2, 0);
        applyStimulus(0, 1, 2, 2);
        checkOutput("drawFlag", drawO[0], 1);
        checkOutput("drawWinner", winO[0], 0);
        checkBoard(0);

        $display("[TB] start with a simultaneous move in game over");
        start[0] = 1'b1; valid[0] = 1'b1; who[0] = 2'b01; rowA = 2'd0; colA = 2'd0;
        tick();
        start[0] = 1'b0; valid[0] = 1'b0;
        clearModel(0);
        mTurn[0] = 1; mInGame[0] = 1'b1;
        checkOutput("restartAck", ack[0], 0);
        checkOutput("restartErr", err[0], 0);
        checkStatus(0);
        checkBoard(0);

        $display("[TB] row win for the player");
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 2, 1, 0);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 2, 1, 1);
        applyStimulus(0, 1, 0, 2);
        checkOutput("rowWinner", winO[0], 1);
        checkOutput("rowCount", countO[0], 5);
        applyStimulus(0, 2, 2, 2);
        checkBoard(0);

        $display("[TB] anti-diagonal win for the computer on 5x5, K=4");
        startGame(1);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 2, 0, 4);
        applyStimulus(1, 1, 0, 1);
        applyStimulus(1, 2, 1, 3);
        applyStimulus(1, 1, 4, 4);
        applyStimulus(1, 2, 2, 2);
        applyStimulus(1, 1, 2, 0);
        applyStimulus(1, 2, 3, 1);
        checkOutput("antiDiagWinner", winO[1], 2);
        checkBoard(1);

        $display("[TB] random games");
        for (int g = 0; g < 8; g++) begin
            int u, attempts;
            u = g % 2;
            startGame(u);
            attempts = 0;
            while (!mOver[u] && attempts < 150) begin
                randomMove(u);
                attempts++;
            end
            checkOutput("gameEnded", over[u], 1);
            checkBoard(u);
        end

        $display("[TB] reset during the line scan");
        startGame(0);
        valid[0] = 1'b1; who[0] = 2'b01; rowA = 2'd1; colA = 2'd2;
        tick();
        valid[0] = 1'b0;
        checkOutput("ackBeforeRst", ack[0], 1);
        tick(); tick(); tick();
        resetAll();
        checkBoard(0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("noAckAfterRst", ack[0], 0);
            checkOutput("noErrAfterRst", err[0], 0);
            checkOutput("idleAfterRst", ready[0], 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
